shift_arbiter: RTL
==================

# shift_arbiter

Round-robin arbiter and sequencer that shares one 8-bit logical-right barrel shifter (zero fill, 3-bit shift amount) among NREQ requesters. Each requester presents an operand and shift amount with a valid/ready handshake. The block grants one request per cycle, drives the shared shifter with the granted operand, and registers the result with the requester's ID into a single-entry output slot that has its own valid/ready backpressure. It sits between the execution-side requesters and the shared shifter datapath.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, derived as max(1, ceil(log2(NREQ))), width of the requester ID. Local, not overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i has a pending request.
- req_data  input  8*NREQ  operand of requester i, in bits [8i+7:8i].
- req_amt  input  3*NREQ  right-shift amount of requester i, in bits [3i+2:3i].
- req_ready  output  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- res_valid  output  1  output slot holds a result.
- res_data  output  8  shifted result.
- res_id  output  IDW  index of the requester that produced res_data.
- res_ready  input  1  consumer accepts the result this cycle.

## Operation
- Shift function: result = req_data[i] >> req_amt[i], logical, zero-filled. An amount of 0 passes the operand through; an amount of 7 leaves only bit 0 of the result, equal to operand bit 7.
- Slot free condition: slot_free = !res_valid || res_ready.
- Grant logic (combinational):
  - Search starts at the round-robin pointer `ptr` and wraps modulo NREQ.
  - The first i with req_valid[i] = 1 is the winner.
  - req_ready[i] = winner && slot_free. Every other bit is 0.
- Accept: a request is accepted when req_valid[i] and req_ready[i] are both high on a clock edge. On accept:
  - res_data <= shifter output for the winner.
  - res_id <= i.
  - res_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Drain: if res_valid && res_ready and no accept happens in the same cycle, then res_valid <= 0. res_data and res_id hold their last values.
- Simultaneous drain and accept: the slot is overwritten with the new result and res_valid stays 1. This is the full-throughput case.
- Pointer update: ptr changes only on accept. With no accept, ptr holds.
- States: EMPTY (res_valid = 0) and FULL (res_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or when res_ready = 0.
  - In FULL with res_ready = 0, req_ready is all zero.
- Requester obligations: hold req_data and req_amt stable while req_valid is high, until accepted. req_valid must not depend on req_ready.
- Output stability: while res_valid = 1 and res_ready = 0, res_data and res_id must remain stable.

## Timing
- Reset values (asynchronous, immediate): res_valid = 0, res_data = 8'h00, res_id = 0, ptr = 0. req_ready is therefore combinationally all-zero while no req_valid is asserted.
- First edge after rst deasserts: the block is fully operational. No warm-up cycles.
- Latency: accept on edge N, res_valid = 1 with the result after edge N (visible in cycle N+1).
- Throughput: one result per cycle while res_ready = 1.
- Fairness: with all NREQ requesters continuously valid and res_ready = 1, grants rotate 0, 1, ..., NREQ-1, 0, ... Any continuously-valid requester waits at most NREQ-1 accepts.
- Reset mid-operation: a pending result is discarded, res_valid drops immediately, and ptr returns to 0. A requester whose request was not accepted before reset must re-present it.
- Combinational paths:
  - req_valid, res_valid, res_ready -> req_ready.
  - No path from req_data/req_amt to any output except through the result register.

## Test plan
- Single request, NREQ=4: requester 2 with data 8'hB4, amt 3, res_ready = 1 -> req_ready = 4'b0100 for one cycle. Next cycle: res_valid = 1, res_data = 8'h16, res_id = 2. Then res_valid = 0.
- Boundary amounts: data 8'hFF with amt 0 -> 8'hFF; data 8'hFF with amt 7 -> 8'h01; data 8'h80 with amt 7 -> 8'h01.
- Fairness: all four valid continuously, res_ready = 1 -> res_id sequence 0,1,2,3,0,1,... with res_valid high every cycle after the first.
- Backpressure: slot FULL with res_ready held 0 for 5 cycles -> req_ready = 0, and res_data/res_id stay constant. Raise res_ready -> the next winner is accepted in the same cycle with no bubble.
- Pointer hold: only requester 3 valid, accepted -> ptr = 0. Then requesters 1 and 2 valid together -> requester 1 wins first, then requester 2.
- Reset mid-operation: assert rst while FULL with res_ready = 0 -> res_valid = 0 and res_data = 8'h00 immediately. After release, requesters 1 and 3 valid -> the first grant goes to requester 1.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit logical-right barrel shifter among NREQ requesters.
// Grants one request per cycle into a single-entry result slot with valid/ready backpressure.
module shift_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [3*NREQ-1:0] req_amt,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   output logic [7:0]        res_data,
   output logic [IDW-1:0]    res_id,
   input  logic              res_ready
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Three-stage logical right shift, zero fill.
   function automatic logic [7:0] shr8(input logic [7:0] d, input logic [2:0] a);
      logic [7:0] s1;
      logic [7:0] s2;
      logic [7:0] s4;
      s1 = a[0] ? {1'b0, d[7:1]}    : d;
      s2 = a[1] ? {2'b00, s1[7:2]}  : s1;
      s4 = a[2] ? {4'h0, s2[7:4]}   : s2;
      return s4;
   endfunction

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end else begin
         sum = sum;
      end
      return sum[IDW-1:0];
   endfunction

   state_t         state_q, state_d;
   logic [7:0]     res_data_q, res_data_d;
   logic [IDW-1:0] res_id_q, res_id_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic           win_found_s;
   logic [IDW-1:0] win_idx_s;
   logic [7:0]     sel_data_s;
   logic [2:0]     sel_amt_s;
   logic           slot_free_s;
   logic           accept_s;

   // Round-robin search starting at ptr_q, wrapping modulo NREQ.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {IDW{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found_s && req_valid[wrap_add(ptr_q, k)]) begin
            win_found_s = 1'b1;
            win_idx_s   = wrap_add(ptr_q, k);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Operand mux for the winner and one-hot ready generation.
   always_comb begin
      sel_data_s  = 8'h00;
      sel_amt_s   = 3'd0;
      req_ready   = {NREQ{1'b0}};
      slot_free_s = (state_q == ST_EMPTY) || res_ready;
      accept_s    = win_found_s && slot_free_s;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx_s == IDW'(i)) begin
            sel_data_s   = req_data[8*i +: 8];
            sel_amt_s    = req_amt[3*i +: 3];
            req_ready[i] = accept_s;
         end else begin
            req_ready[i] = 1'b0;
         end
      end
   end

   // Slot FSM and next-state values for the result register and pointer.
   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      ptr_d      = ptr_q;
      case (state_q)
         ST_EMPTY: state_d = accept_s ? ST_FULL : ST_EMPTY;
         ST_FULL:  state_d = (accept_s || !res_ready) ? ST_FULL : ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (accept_s) begin
         res_data_d = shr8(sel_data_s, sel_amt_s);
         res_id_d   = win_idx_s;
         ptr_d      = (win_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : win_idx_s + IDW'(1);
      end else begin
         res_data_d = res_data_q;
         res_id_d   = res_id_q;
         ptr_d      = ptr_q;
      end
   end

   // State, result slot and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         res_data_q <= 8'h00;
         res_id_q   <= {IDW{1'b0}};
         ptr_q      <= {IDW{1'b0}};
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         ptr_q      <= ptr_d;
      end
   end

   assign res_valid = (state_q == ST_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule
